control_barrera: RTL and testbench

- Single-lane barrier controller sitting between the debounced entry/exit request buttons and the occupancy counter.
- Arbitrates the shared barrier between entry and exit requesters.
- Checks occupancy before granting, opens the barrier and waits for the vehicle-passed sensor.
- Issues exactly one increment/decrement pulse to the counter per completed passage, then enforces a closing interval before the next grant.

---
 rtl/control_barrera.sv | 158 +++++++++++++++
 tb/tb_control_barrera.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_barrera.sv
// Single-lane barrier controller: arbitrates entry/exit requests, checks occupancy,
// opens the barrier until a passage or timeout, pulses the counter and waits out the closing time.
`timescale 1ns/1ps
module control_barrera #(
   parameter int CW        = 3,
   parameter int CAPACIDAD = 7,
   parameter int T_ABIERTO = 50000000,
   parameter int T_CIERRE  = 25000000
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          req_in,
   input  logic          req_out,
   input  logic          paso,
   input  logic [CW-1:0] cuenta,
   input  logic          lleno,
   output logic          barrera,
   output logic          inc,
   output logic          dec,
   output logic          rechazo,
   output logic          ocupado,
   output logic [1:0]    estado
);

   localparam int T_MAX = (T_ABIERTO > T_CIERRE) ? T_ABIERTO : T_CIERRE;
   localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
   localparam logic [TW-1:0] AB_LAST = TW'(T_ABIERTO - 1);
   localparam logic [TW-1:0] CI_LAST = TW'(T_CIERRE - 1);
   localparam logic [CW:0]   CAP_W   = (CW+1)'(CAPACIDAD);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_AB_IN   = 2'd1,
      S_AB_OUT  = 2'd2,
      S_CIERRE  = 2'd3
   } state_t;

   state_t        state_reg;
   logic          barrera_reg, inc_reg, dec_reg, rechazo_reg, ocupado_reg;
   logic          pend_in_reg, pend_out_reg, ult_reg;
   logic [TW-1:0] timer_reg;
   logic [TW-1:0] timer_next;

   logic [2:0] lvl;
   logic [2:0] edge_det;
   logic       edge_in, edge_out, edge_paso;
   logic       pick_in, pick_out, in_ok, out_ok;

   assign lvl = {paso, req_out, req_in};

   // Reset loads the current level so a button held through reset is not a request.
   for (genvar gi = 0; gi < 3; gi++) begin : g_edge
      logic sync_reg, prev_reg;
      always_ff @(posedge CLK) begin
         if (RST) begin
            sync_reg <= lvl[gi];
            prev_reg <= lvl[gi];
         end else begin
            sync_reg <= lvl[gi];
            prev_reg <= sync_reg;
         end
      end
      assign edge_det[gi] = sync_reg & ~prev_reg;
   end

   assign edge_in   = edge_det[0];
   assign edge_out  = edge_det[1];
   assign edge_paso = edge_det[2];

   // On a tie the side not served last wins (ult = 1 means exit was last).
   assign pick_in  = pend_in_reg & (~pend_out_reg | ult_reg);
   assign pick_out = pend_out_reg & ~pick_in;
   assign in_ok    = ({1'b0, cuenta} < CAP_W) && !lleno;
   assign out_ok   = (cuenta != '0);

   assign timer_next = (timer_reg == {TW{1'b1}}) ? timer_reg : timer_reg + 1'b1;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= S_IDLE;
         barrera_reg  <= 1'b0;
         inc_reg      <= 1'b0;
         dec_reg      <= 1'b0;
         rechazo_reg  <= 1'b0;
         ocupado_reg  <= 1'b0;
         pend_in_reg  <= 1'b0;
         pend_out_reg <= 1'b0;
         ult_reg      <= 1'b1;
         timer_reg    <= '0;
      end else begin
         inc_reg     <= 1'b0;
         dec_reg     <= 1'b0;
         rechazo_reg <= 1'b0;
         if (edge_in)  pend_in_reg  <= 1'b1;
         if (edge_out) pend_out_reg <= 1'b1;
         case (state_reg)
            S_IDLE: begin
               if (pick_in) begin
                  pend_in_reg <= 1'b0;
                  if (in_ok) begin
                     barrera_reg <= 1'b1;
                     ocupado_reg <= 1'b1;
                     timer_reg   <= '0;
                     ult_reg     <= 1'b0;
                     state_reg   <= S_AB_IN;
                  end else begin
                     rechazo_reg <= 1'b1;
                  end
               end else if (pick_out) begin
                  pend_out_reg <= 1'b0;
                  if (out_ok) begin
                     barrera_reg <= 1'b1;
                     ocupado_reg <= 1'b1;
                     timer_reg   <= '0;
                     ult_reg     <= 1'b1;
                     state_reg   <= S_AB_OUT;
                  end else begin
                     rechazo_reg <= 1'b1;
                  end
               end
            end
            S_AB_IN, S_AB_OUT: begin
               timer_reg <= timer_next;
               // A passage coinciding with the timeout still earns its pulse.
               if (edge_paso) begin
                  inc_reg     <= (state_reg == S_AB_IN);
                  dec_reg     <= (state_reg == S_AB_OUT);
                  barrera_reg <= 1'b0;
                  timer_reg   <= '0;
                  state_reg   <= S_CIERRE;
               end else if (timer_reg == AB_LAST) begin
                  barrera_reg <= 1'b0;
                  timer_reg   <= '0;
                  state_reg   <= S_CIERRE;
               end
            end
            S_CIERRE: begin
               if (timer_reg == CI_LAST) begin
                  timer_reg   <= '0;
                  ocupado_reg <= 1'b0;
                  state_reg   <= S_IDLE;
               end else begin
                  timer_reg <= timer_next;
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   assign barrera = barrera_reg;
   assign inc     = inc_reg;
   assign dec     = dec_reg;
   assign rechazo = rechazo_reg;
   assign ocupado = ocupado_reg;
   assign estado  = state_reg;

endmodule

// File: tb/tb_control_barrera.sv
// Bench for control_barrera: table of single requests plus tie, busy and reset sequences;
// counter pulses are checked against an expected-event queue.
`timescale 1ns/1ps
module tb_control_barrera;

   localparam int T_AB = 8;
   localparam int T_CI = 4;
   localparam int EV_INC = 1;
   localparam int EV_DEC = 2;
   localparam int EV_REJ = 3;

   logic       CLK = 1'b0;
   logic       RST, req_in, req_out, paso, lleno;
   logic [2:0] cuenta;
   logic       barrera, inc, dec, rechazo, ocupado;
   logic [1:0] estado;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int mon_got, mon_exp;

   control_barrera #(.CW(3), .CAPACIDAD(7), .T_ABIERTO(T_AB), .T_CIERRE(T_CI)) dut (
      .CLK(CLK), .RST(RST), .req_in(req_in), .req_out(req_out), .paso(paso),
      .cuenta(cuenta), .lleno(lleno), .barrera(barrera), .inc(inc), .dec(dec),
      .rechazo(rechazo), .ocupado(ocupado), .estado(estado)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Every counter/refusal pulse must match the next expected event, in order.
   always @(negedge CLK) begin
      if (inc || dec || rechazo) begin
         mon_got = inc ? EV_INC : (dec ? EV_DEC : EV_REJ);
         checks++;
         if (inc && dec) begin
            errors++;
            $display("FAIL pulse_exclusive: got inc=1 dec=1 expected at most one");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pulse_unexpected: got event %0d expected none", mon_got);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got != mon_exp) begin
               errors++;
               $display("FAIL pulse_order: got event %0d expected %0d", mon_got, mon_exp);
            end
         end
      end
   end

   function automatic bit pulse_of(input int d);
      return (d >= 0) && (d <= T_AB - 2);
   endfunction

   // Raise the chosen requests at cycle n; returns at cycle n+3.
   task automatic raise_req(input bit do_in, input bit do_out);
      if (do_in)  req_in  = 1'b1;
      if (do_out) req_out = 1'b1;
      tick;
      tick;
      chk("barrera_low_at_n2", barrera, 1'b0);
      tick;
      if (do_in)  req_in  = 1'b0;
      if (do_out) req_out = 1'b0;
   endtask

   // Called in the first open cycle; drives paso d cycles later (d<0: never) and
   // returns in the first IDLE cycle after closing.
   task automatic run_open(input bit ex, input int d, input bit busy);
      int  k, cnt, cc, exp_open;
      bit  pulse;
      pulse    = pulse_of(d);
      exp_open = pulse ? d + 2 : T_AB;
      k   = 0;
      cnt = 0;
      while (barrera === 1'b1 && k < 40) begin
         cnt++;
         if (k == d) paso = 1'b1;
         if (busy) begin
            if (k == 1) exp_q.push_back(EV_DEC);
            if (k == 1 || k == 3) req_out = 1'b1;
            if (k == 2 || k == 4) req_out = 1'b0;
         end
         tick;
         k++;
      end
      chk("open_cycles", cnt, exp_open);
      chk("estado_cierre", estado, 2'd3);
      chk("inc_at_close", inc, pulse && !ex);
      chk("dec_at_close", dec, pulse && ex);
      paso = 1'b0;
      cc = 0;
      while (estado === 2'd3 && cc < 40) begin
         cc++;
         if (busy && cc == 2) paso = 1'b1;
         if (busy && cc == 3) paso = 1'b0;
         tick;
      end
      chk("cierre_cycles", cc, T_CI);
      chk("ocupado_idle", ocupado, 1'b0);
      chk("estado_idle", estado, 2'd0);
   endtask

   task automatic do_reset;
      RST = 1'b1;
      tick;
      tick;
      RST = 1'b0;
      tick;
   endtask

   typedef struct {
      bit         ex;
      logic [2:0] cuenta;
      bit         lleno;
      int         d;
      bit         grant;
   } vec_t;

   vec_t vecs[10];

   initial begin
      int  busy_seen;
      RST = 1'b1; req_in = 1'b0; req_out = 1'b0; paso = 1'b0;
      cuenta = 3'd0; lleno = 1'b0;

      vecs[0] = '{1'b0, 3'd0, 1'b0,  3, 1'b1};  // basic entry
      vecs[1] = '{1'b1, 3'd3, 1'b0,  0, 1'b1};  // quick exit
      vecs[2] = '{1'b0, 3'd7, 1'b1,  3, 1'b0};  // full: refuse entry
      vecs[3] = '{1'b1, 3'd0, 1'b0,  3, 1'b0};  // empty: refuse exit
      vecs[4] = '{1'b0, 3'd0, 1'b0, -1, 1'b1};  // timeout
      vecs[5] = '{1'b0, 3'd6, 1'b0,  6, 1'b1};  // paso coincides with timeout
      vecs[6] = '{1'b0, 3'd7, 1'b0,  3, 1'b0};  // cuenta at capacity
      vecs[7] = '{1'b0, 3'd5, 1'b1,  3, 1'b0};  // lleno alone refuses
      vecs[8] = '{1'b1, 3'd7, 1'b1,  7, 1'b1};  // paso after timeout ignored
      vecs[9] = '{1'b1, 3'd1, 1'b0,  1, 1'b1};  // last car exits

      tick; tick; tick;
      chk("rst_barrera", barrera, 1'b0);
      chk("rst_inc", inc, 1'b0);
      chk("rst_dec", dec, 1'b0);
      chk("rst_rechazo", rechazo, 1'b0);
      chk("rst_ocupado", ocupado, 1'b0);
      chk("rst_estado", estado, 2'd0);
      RST = 1'b0;
      tick;

      for (int i = 0; i < 10; i++) begin
         $display("vec %0d: exit=%0d cuenta=%0d lleno=%0d paso_dly=%0d grant=%0d",
                  i, vecs[i].ex, vecs[i].cuenta, vecs[i].lleno, vecs[i].d, vecs[i].grant);
         cuenta = vecs[i].cuenta;
         lleno  = vecs[i].lleno;
         tick;
         chk("vec_start_idle", estado, 2'd0);
         if (!vecs[i].grant)           exp_q.push_back(EV_REJ);
         else if (pulse_of(vecs[i].d)) exp_q.push_back(vecs[i].ex ? EV_DEC : EV_INC);
         raise_req(!vecs[i].ex, vecs[i].ex);
         if (vecs[i].grant) begin
            chk("grant_barrera", barrera, 1'b1);
            chk("grant_ocupado", ocupado, 1'b1);
            chk("grant_estado", estado, vecs[i].ex ? 2'd2 : 2'd1);
            run_open(vecs[i].ex, vecs[i].d, 1'b0);
         end else begin
            chk("refuse_rechazo", rechazo, 1'b1);
            chk("refuse_barrera", barrera, 1'b0);
            chk("refuse_ocupado", ocupado, 1'b0);
            tick;
            chk("refuse_one_cycle", rechazo, 1'b0);
            chk("refuse_stays_idle", estado, 2'd0);
         end
      end

      $display("seq tie: entry then exit after reset");
      do_reset;
      cuenta = 3'd3; lleno = 1'b0;
      exp_q.push_back(EV_INC);
      exp_q.push_back(EV_DEC);
      raise_req(1'b1, 1'b1);
      chk("tie1_entry_first", estado, 2'd1);
      run_open(1'b0, 2, 1'b0);
      tick;
      chk("tie1_exit_next", estado, 2'd2);
      chk("tie1_exit_barrera", barrera, 1'b1);
      run_open(1'b1, 1, 1'b0);

      $display("seq tie: entry alone, then tie served exit first");
      exp_q.push_back(EV_INC);
      raise_req(1'b1, 1'b0);
      chk("solo_entry", estado, 2'd1);
      run_open(1'b0, 0, 1'b0);
      exp_q.push_back(EV_DEC);
      exp_q.push_back(EV_INC);
      raise_req(1'b1, 1'b1);
      chk("tie2_exit_first", estado, 2'd2);
      run_open(1'b1, 3, 1'b0);
      tick;
      chk("tie2_entry_next", estado, 2'd1);
      run_open(1'b0, 3, 1'b0);

      $display("seq busy: two exit presses while open, paso during closing");
      exp_q.push_back(EV_INC);
      raise_req(1'b1, 1'b0);
      chk("busy_entry", estado, 2'd1);
      run_open(1'b0, 5, 1'b1);
      tick;
      chk("busy_exit_served", estado, 2'd2);
      run_open(1'b1, 0, 1'b0);
      busy_seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (estado !== 2'd0) busy_seen = 1;
      end
      chk("busy_second_exit_dropped", busy_seen, 0);

      $display("seq reset: RST during exit with entry pending");
      exp_q.push_back(EV_REJ);
      exp_q.delete();
      raise_req(1'b0, 1'b1);
      chk("rst_seq_open", estado, 2'd2);
      req_in = 1'b1;
      tick; tick; tick;
      chk("rst_seq_still_open", barrera, 1'b1);
      RST = 1'b1;
      tick;
      chk("rst_mid_barrera", barrera, 1'b0);
      chk("rst_mid_estado", estado, 2'd0);
      chk("rst_mid_ocupado", ocupado, 1'b0);
      chk("rst_mid_pulses", {inc, dec, rechazo}, 3'b000);
      RST = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (estado !== 2'd0 || barrera !== 1'b0) busy_seen = 1;
      end
      chk("rst_no_grant_after", busy_seen, 0);
      req_in = 1'b0;
      tick; tick;

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
